alu8_mul_seq: RTL and testbench

Multi-cycle unsigned 8x8 multiplier sequencer that drives the shared 8-bit ALU. It runs the classic shift-add algorithm:

- The ALU's ADD operation (control 000) and its carry flag form each partial sum.
- The sequencer's own registers perform the combined right shift.

It sits beside the ALU in the datapath and is started by the control unit with a single-cycle start pulse. It returns a 16-bit product with a done pulse.

---
 rtl/alu8_mul_seq.sv | 112 +++++++++++
 tb/tb_alu8_mul_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu8_mul_seq.sv
// Shift-add unsigned multiplier sequencer that borrows the shared ALU for its partial sums.
// The ALU adds in ADD states; this block does the combined {C,A,Q} right shift itself.
module alu8_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           aluOp,
    output logic [WIDTH-1:0]     aluA,
    output logic [WIDTH-1:0]     aluB,
    input  logic [WIDTH-1:0]     aluResult,
    input  logic                 aluCarry
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_MOV = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } stateT;

    stateT                stateReg;
    logic [WIDTH-1:0]     mReg;
    logic [WIDTH-1:0]     qReg;
    logic [WIDTH-1:0]     aReg;
    logic                 cReg;
    logic [CW-1:0]        cntReg;
    logic                 busyReg;
    logic                 doneReg;
    logic [2*WIDTH-1:0]   productReg;
    logic                 addSelect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            mReg       <= '0;
            qReg       <= '0;
            aReg       <= '0;
            cReg       <= 1'b0;
            cntReg     <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            productReg <= '0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        mReg     <= mcand;
                        qReg     <= mplier;
                        aReg     <= '0;
                        cReg     <= 1'b0;
                        cntReg   <= '0;
                        busyReg  <= 1'b1;
                        stateReg <= ADD;
                    end
                end
                ADD: begin
                    aReg     <= aluResult;
                    cReg     <= aluCarry;
                    stateReg <= SHIFT;
                end
                SHIFT: begin
                    // C drops into A's MSB while A's LSB moves into Q's MSB
                    aReg <= {cReg, aReg[WIDTH-1:1]};
                    qReg <= {aReg[0], qReg[WIDTH-1:1]};
                    cReg <= 1'b0;
                    if (cntReg == LAST_STEP) begin
                        productReg <= {cReg, aReg, qReg[WIDTH-1:1]};
                        doneReg    <= 1'b1;
                        busyReg    <= 1'b0;
                        cntReg     <= '0;
                        stateReg   <= IDLE;
                    end else begin
                        cntReg   <= cntReg + CW'(1);
                        stateReg <= ADD;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busyReg;
    assign done    = doneReg;
    assign product = productReg;
    assign aluOp   = (stateReg == ADD) ? ALU_ADD : ALU_MOV;
    assign aluA    = aReg;

    // Multiplicand is gated bitwise by the current multiplier LSB during ADD only
    assign addSelect = (stateReg == ADD) && qReg[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gBGate
            assign aluB[gi] = addSelect & mReg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_alu8_mul_seq.sv
// Randomised scoreboard bench for alu8_mul_seq; a bench-side model of the shared ALU closes the loop.
module tb_alu8_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  mcand = 8'h00;
    logic [7:0]  mplier = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [2:0]  aluOp;
    logic [7:0]  aluA;
    logic [7:0]  aluB;
    logic [7:0]  aluResult;
    logic        aluCarry;
    logic [8:0]  aluSum;

    alu8_mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .aluOp     (aluOp),
        .aluA      (aluA),
        .aluB      (aluB),
        .aluResult (aluResult),
        .aluCarry  (aluCarry)
    );

    // Shared ALU: ADD gives a 9-bit sum, MOV passes operand b with no carry
    assign aluSum    = (aluOp == 3'b000) ? ({1'b0, aluA} + {1'b0, aluB}) : {1'b0, aluB};
    assign aluResult = aluSum[7:0];
    assign aluCarry  = aluSum[8];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         acceptCyc;
        int         doneCyc;
    } jobT;

    jobT         sb[$];
    int          busyUntil = 0;
    int          nChecks = 0;
    int          nPass = 0;
    int          nJobs = 0;
    logic [15:0] heldProduct = 16'h0000;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every expected completion
    jobT  mj;
    int   off;
    int   bitIdx;
    logic expDone;
    logic active;
    logic [15:0] expProd;
    logic [15:0] partial;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_product", int'(product), 0);
            chk("rst_aluOp", int'(aluOp), 1);
            chk("rst_aluA", int'(aluA), 0);
            chk("rst_aluB", int'(aluB), 0);
            heldProduct = 16'h0000;
        end else begin
            expDone = (sb.size() > 0) && (cyc == sb[0].doneCyc);
            chk("done", int'(done), int'(expDone));
            if (expDone) begin
                mj = sb.pop_front();
                expProd = 16'(mj.a) * 16'(mj.b);
                chk("product", int'(product), int'(expProd));
                $display("txn %0d: 0x%02h * 0x%02h -> product 0x%04h (expected 0x%04h) at cycle %0d",
                         nJobs, mj.a, mj.b, product, expProd, cyc);
                nJobs++;
                heldProduct = expProd;
            end else begin
                chk("product_hold", int'(product), int'(heldProduct));
            end

            active = (sb.size() > 0) && (cyc >= sb[0].acceptCyc) && (cyc < sb[0].doneCyc);
            chk("busy", int'(busy), int'(active));
            if (active) begin
                off    = cyc - sb[0].acceptCyc;
                bitIdx = off / 2;
                if (off % 2 == 0) begin
                    chk("aluOp_add", int'(aluOp), 0);
                    // Accumulator holds the low-bit partial product shifted down by the bits consumed
                    partial = (16'(sb[0].a) * 16'(sb[0].b & 8'((16'd1 << bitIdx) - 16'd1))) >> bitIdx;
                    chk("aluA", int'(aluA), int'(partial));
                    chk("aluB", int'(aluB), sb[0].b[bitIdx] ? int'(sb[0].a) : 0);
                end else begin
                    chk("aluOp_shift", int'(aluOp), 1);
                    chk("aluB_shift", int'(aluB), 0);
                end
            end else begin
                chk("aluOp_idle", int'(aluOp), 1);
                chk("aluB_idle", int'(aluB), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input logic [7:0] a, input logic [7:0] b);
        jobT j;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        if (rst_n && cyc >= busyUntil) begin
            j.a         = a;
            j.b         = b;
            j.acceptCyc = cyc + 1;
            j.doneCyc   = cyc + 17;
            sb.push_back(j);
            busyUntil   = cyc + 17;
        end
        step();
        start  = 1'b0;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
    endtask

    task automatic waitIdle();
        while (cyc < busyUntil) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        doStart(8'h0D, 8'h0B);
        waitIdle();
        repeat (2) step();

        doStart(8'hFF, 8'hFF);
        waitIdle();
        doStart(8'h00, 8'hFF);
        waitIdle();
        doStart(8'hFF, 8'h00);
        waitIdle();
        step();

        // Second start lands mid-operation and must be ignored
        doStart(8'h03, 8'h05);
        repeat (4) step();
        doStart(8'h10, 8'h10);
        waitIdle();
        repeat (2) step();

        // Back-to-back: new start issued in the done cycle
        doStart(8'h02, 8'h03);
        waitIdle();
        doStart(8'h80, 8'h02);
        waitIdle();
        repeat (2) step();

        // Reset in the middle of a multiply drops it without a done pulse
        doStart(8'hAA, 8'h55);
        repeat (7) step();
        rst_n = 1'b0;
        sb.delete();
        busyUntil = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        doStart(8'h07, 8'h09);
        waitIdle();

        for (int k = 0; k < 24; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            waitIdle();
            repeat (gap) step();
            doStart(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 12)) step();
                doStart(8'($urandom), 8'($urandom));
            end
        end
        waitIdle();
        repeat (3) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
